// File: rtl/mii_rx_capture_if.sv
// Bundle between the MII receive capture stage and its neighbours:
// MII stream and parser handshake in, frame RAM write port and status out.
interface mii_rx_capture_if #(
    parameter int ADDR_W = 9
) ();
    logic              mii_rx_dv;
    logic [3:0]        mii_rxd;
    logic              mii_rx_er;
    logic              parser_busy;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ena;
    logic              newpacket;
    logic [ADDR_W-1:0] frame_last_addr;
    logic              overflow;
    logic [15:0]       drop_count;

    modport master (
        input  mii_rx_dv, mii_rxd, mii_rx_er, parser_busy,
        output wr_data, wr_addr, wr_ena, newpacket, frame_last_addr, overflow, drop_count
    );

    modport slave (
        output mii_rx_dv, mii_rxd, mii_rx_er, parser_busy,
        input  wr_data, wr_addr, wr_ena, newpacket, frame_last_addr, overflow, drop_count
    );
endinterface

// File: rtl/mii_rx_capture.sv
// Packs the MII receive nibble stream into 32-bit words, stores each frame
// from address 0 of the frame RAM and announces good frames to the parser.
module mii_rx_capture #(
    parameter int ADDR_W    = 9,
    parameter int MIN_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    mii_rx_capture_if.master  bus
);
    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] ONE_IDX   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] MIN_IDX   = (ADDR_W+1)'(MIN_WORDS);

    // Nibble n lands in byte n/2; the first nibble of a byte takes the upper half.
    function automatic logic [31:0] place_nibble(input logic [3:0] nib, input logic [2:0] pos);
        logic [4:0] sh;
        sh = {pos[2:1], 3'b000} + (pos[0] ? 5'd0 : 5'd4);
        return {28'd0, nib} << sh;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    state_t            state_r, state_s;
    logic [31:0]       word_r, word_s, cur_word_s;
    logic [2:0]        nib_cnt_r, nib_cnt_s;
    logic [ADDR_W:0]   idx_r, idx_s, last_idx_s;
    logic [31:0]       wr_data_r, wr_data_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic              wr_ena_r, wr_ena_s;
    logic              newpacket_r, newpacket_s;
    logic [ADDR_W-1:0] fla_r, fla_s;
    logic              overflow_r, overflow_s;
    logic [15:0]       drop_r, drop_s;
    logic [1:0]        drop_inc_s;

    assign cur_word_s = word_r | place_nibble(bus.mii_rxd, nib_cnt_r);

    // Next-state and next-output logic for the capture FSM.
    always_comb begin
        state_s     = state_r;
        word_s      = word_r;
        nib_cnt_s   = nib_cnt_r;
        idx_s       = idx_r;
        wr_data_s   = wr_data_r;
        wr_addr_s   = wr_addr_r;
        wr_ena_s    = 1'b0;
        newpacket_s = 1'b0;
        fla_s       = fla_r;
        overflow_s  = overflow_r;
        drop_inc_s  = 2'd0;
        last_idx_s  = idx_r - ONE_IDX;
        case (state_r)
            WAIT_GAP: begin
                if (!bus.mii_rx_dv) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_GAP;
                end
            end
            IDLE: begin
                if (!bus.mii_rx_dv) begin
                    state_s = IDLE;
                end else if (bus.parser_busy || bus.mii_rx_er) begin
                    drop_inc_s = 2'd1;
                    state_s    = WAIT_GAP;
                end else begin
                    word_s     = place_nibble(bus.mii_rxd, 3'd0);
                    nib_cnt_s  = 3'd1;
                    idx_s      = {(ADDR_W+1){1'b0}};
                    overflow_s = 1'b0;
                    state_s    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!bus.mii_rx_dv) begin
                    // End of frame: flush a partial word, unfilled nibbles stay zero.
                    word_s    = 32'd0;
                    nib_cnt_s = 3'd0;
                    if (nib_cnt_r == 3'd0) begin
                        state_s = DONE;
                    end else if (idx_r[ADDR_W]) begin
                        overflow_s = 1'b1;
                        drop_inc_s = 2'd1;
                        state_s    = WAIT_GAP;
                    end else begin
                        wr_data_s = word_r;
                        wr_addr_s = idx_r[ADDR_W-1:0];
                        wr_ena_s  = 1'b1;
                        idx_s     = idx_r + ONE_IDX;
                        state_s   = DONE;
                    end
                end else if (bus.mii_rx_er) begin
                    drop_inc_s = 2'd1;
                    state_s    = WAIT_GAP;
                end else if (nib_cnt_r == 3'd7) begin
                    word_s    = 32'd0;
                    nib_cnt_s = 3'd0;
                    if (idx_r[ADDR_W]) begin
                        overflow_s = 1'b1;
                        drop_inc_s = 2'd1;
                        state_s    = WAIT_GAP;
                    end else begin
                        wr_data_s = cur_word_s;
                        wr_addr_s = idx_r[ADDR_W-1:0];
                        wr_ena_s  = 1'b1;
                        idx_s     = idx_r + ONE_IDX;
                    end
                end else begin
                    word_s    = cur_word_s;
                    nib_cnt_s = nib_cnt_r + 3'd1;
                end
            end
            DONE: begin
                // A frame that restarts here is dropped; the one just stored is still judged.
                if (idx_r >= MIN_IDX) begin
                    newpacket_s = 1'b1;
                    fla_s       = last_idx_s[ADDR_W-1:0];
                end else begin
                    drop_inc_s = 2'd1;
                end
                if (bus.mii_rx_dv) begin
                    drop_inc_s = drop_inc_s + 2'd1;
                    state_s    = WAIT_GAP;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = WAIT_GAP;
            end
        endcase
        drop_s = sat_add(drop_r, drop_inc_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_GAP;
            word_r      <= 32'd0;
            nib_cnt_r   <= 3'd0;
            idx_r       <= {(ADDR_W+1){1'b0}};
            wr_data_r   <= 32'd0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_ena_r    <= 1'b0;
            newpacket_r <= 1'b0;
            fla_r       <= {ADDR_W{1'b0}};
            overflow_r  <= 1'b0;
            drop_r      <= 16'd0;
        end else begin
            state_r     <= state_s;
            word_r      <= word_s;
            nib_cnt_r   <= nib_cnt_s;
            idx_r       <= idx_s;
            wr_data_r   <= wr_data_s;
            wr_addr_r   <= wr_addr_s;
            wr_ena_r    <= wr_ena_s;
            newpacket_r <= newpacket_s;
            fla_r       <= fla_s;
            overflow_r  <= overflow_s;
            drop_r      <= drop_s;
        end
    end

    assign bus.wr_data         = wr_data_r;
    assign bus.wr_addr         = wr_addr_r;
    assign bus.wr_ena          = wr_ena_r;
    assign bus.newpacket       = newpacket_r;
    assign bus.frame_last_addr = fla_r;
    assign bus.overflow        = overflow_r;
    assign bus.drop_count      = drop_r;
endmodule

// File: tb/tb_mii_rx_capture.sv
// Directed bench for mii_rx_capture: drives MII frames, records RAM writes
// and newpacket pulses, and checks them against hand-computed values.
module tb_mii_rx_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    mii_rx_capture_if #(.ADDR_W(9)) bus ();

    mii_rx_capture #(.ADDR_W(9), .MIN_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/pulse recorder, sampled on the falling edge.
    logic [31:0] mem [0:511];
    int          wr_cnt = 0, np_cnt = 0, both_cnt = 0;
    int          last_wr_cyc = 0, np_cyc = 0;
    logic [8:0]  np_fla = 9'd0;
    always @(negedge clk) begin
        if (bus.wr_ena) begin
            mem[bus.wr_addr] = bus.wr_data;
            wr_cnt           = wr_cnt + 1;
            last_wr_cyc      = cyc;
        end
        if (bus.newpacket) begin
            np_cnt = np_cnt + 1;
            np_fla = bus.frame_last_addr;
            np_cyc = cyc;
        end
        if (bus.wr_ena && bus.newpacket) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 16 x 5, then SFD byte D5 (5,D), then payload bytes A5 sent as 5,A.
    function automatic logic [3:0] nib_at(input int i);
        if (i < 17)       return 4'h5;
        else if (i == 17) return 4'hD;
        else if (i % 2 == 0) return 4'h5;
        else              return 4'hA;
    endfunction

    task automatic send_frame(input int n, input int er_at, input int busy_until,
                              input int rst_at, output int fall_cyc);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.mii_rx_dv   = 1'b1;
            bus.mii_rxd     = nib_at(i);
            bus.mii_rx_er   = (i == er_at);
            bus.parser_busy = (i < busy_until);
            rst             = (i == rst_at);
        end
        @(posedge clk); #1;
        bus.mii_rx_dv   = 1'b0;
        bus.mii_rx_er   = 1'b0;
        bus.parser_busy = 1'b0;
        rst             = 1'b0;
        fall_cyc        = cyc;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    int fc, w0, n0, b0;

    initial begin
        bus.mii_rx_dv   = 1'b0;
        bus.mii_rxd     = 4'h0;
        bus.mii_rx_er   = 1'b0;
        bus.parser_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'd0);
        chk("rst_wr_ena", bus.wr_ena, 32'd0);
        chk("rst_newpacket", bus.newpacket, 32'd0);
        chk("rst_fla", bus.frame_last_addr, 32'd0);
        chk("rst_overflow", bus.overflow, 32'd0);
        chk("rst_drop", bus.drop_count, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(posedge clk);

        // Good frame: 110 nibbles -> 13 full words + 6-nibble padded word.
        w0 = wr_cnt; n0 = np_cnt; b0 = both_cnt;
        send_frame(110, -1, 0, -1, fc);
        chk("good_writes", wr_cnt - w0, 32'd14);
        chk("good_np", np_cnt - n0, 32'd1);
        chk("good_fla", np_fla, 32'd13);
        chk("good_pad_wr_cyc", last_wr_cyc, fc + 1);
        chk("good_np_cyc", np_cyc, fc + 2);
        chk("good_np_wr_overlap", both_cnt - b0, 32'd0);
        chk("good_word0", mem[0], 32'h55555555);
        chk("good_word1", mem[1], 32'h55555555);
        chk("good_word2", mem[2], 32'h5A5A5A5D);
        chk("good_word7", mem[7], 32'h5A5A5A5A);
        chk("good_word13", mem[13], 32'h005A5A5A);
        chk("good_drop", bus.drop_count, 32'd0);

        // Exact multiple: 64 nibbles -> 8 writes, no pad.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, -1, 0, -1, fc);
        chk("exact_writes", wr_cnt - w0, 32'd8);
        chk("exact_last_wr_cyc", last_wr_cyc, fc);
        chk("exact_np", np_cnt - n0, 32'd1);
        chk("exact_fla", np_fla, 32'd7);
        chk("exact_np_cyc", np_cyc, fc + 2);

        // Runt: 20 nibbles -> 3 writes, dropped.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(20, -1, 0, -1, fc);
        chk("runt_writes", wr_cnt - w0, 32'd3);
        chk("runt_np", np_cnt - n0, 32'd0);
        chk("runt_drop", bus.drop_count, 32'd1);

        // Receive error at nibble 40: 5 words already written, then dropped.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, 40, 0, -1, fc);
        chk("err_writes", wr_cnt - w0, 32'd5);
        chk("err_np", np_cnt - n0, 32'd0);
        chk("err_drop", bus.drop_count, 32'd2);
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, -1, 0, -1, fc);
        chk("after_err_writes", wr_cnt - w0, 32'd8);
        chk("after_err_np", np_cnt - n0, 32'd1);
        chk("after_err_fla", np_fla, 32'd7);

        // Parser busy at frame start, released mid-frame.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, -1, 10, -1, fc);
        chk("busy_writes", wr_cnt - w0, 32'd0);
        chk("busy_np", np_cnt - n0, 32'd0);
        chk("busy_drop", bus.drop_count, 32'd3);

        // Overflow: 4104 nibbles = 513 words, only 512 fit.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(4104, -1, 0, -1, fc);
        chk("ovf_writes", wr_cnt - w0, 32'd512);
        chk("ovf_flag", bus.overflow, 32'd1);
        chk("ovf_np", np_cnt - n0, 32'd0);
        chk("ovf_drop", bus.drop_count, 32'd4);
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, -1, 0, -1, fc);
        chk("after_ovf_flag", bus.overflow, 32'd0);
        chk("after_ovf_np", np_cnt - n0, 32'd1);
        chk("after_ovf_writes", wr_cnt - w0, 32'd8);

        // Reset at nibble 30 with dv held high: 3 words before reset, none after.
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(40, -1, 0, 30, fc);
        chk("rstmid_writes", wr_cnt - w0, 32'd3);
        chk("rstmid_np", np_cnt - n0, 32'd0);
        chk("rstmid_drop", bus.drop_count, 32'd0);
        chk("rstmid_wr_ena", bus.wr_ena, 32'd0);
        chk("rstmid_fla", bus.frame_last_addr, 32'd0);
        w0 = wr_cnt; n0 = np_cnt;
        send_frame(64, -1, 0, -1, fc);
        chk("after_rst_writes", wr_cnt - w0, 32'd8);
        chk("after_rst_np", np_cnt - n0, 32'd1);
        chk("after_rst_fla", np_fla, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
